// File: rtl/image_pipe_stage.sv
// rtl/image_pipe_stage.sv - multi-lane pixel offset stage with end-of-line tagging and output FIFO
module image_pipe_stage #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int SAT   = 1,
  parameter int LL_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIX_W-1:0]           cfg_offset,
  input  logic [LL_W-1:0]            cfg_line_len,
  input  logic [PIX_W*LANES-1:0]     is_data_in,
  input  logic                       is_valid_in,
  output logic                       is_busy_out,
  output logic [PIX_W*LANES-1:0]     im_data_out,
  output logic                       im_eol_out,
  output logic                       im_valid_out,
  input  logic                       im_busy_in,
  output logic [$clog2(DEPTH):0]     level_out
);

  localparam int DW = PIX_W * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]   data_mem_q [DEPTH];
  logic            eol_mem_q  [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [LL_W-1:0] col_q, col_d;

  logic            push;
  logic            pop;
  logic            full;
  logic [DW-1:0]   proc_data;
  logic [PIX_W:0]  lane_sum;
  logic            eol_tag;

  // Busy depends on the registered count only, so a pop cannot free a slot for the same edge.
  assign full         = (count_q == CW'(DEPTH));
  assign is_busy_out  = full;
  assign im_valid_out = (count_q != '0);
  assign level_out    = count_q;
  assign push         = is_valid_in && !full;
  assign pop          = im_valid_out && !im_busy_in;

  // Head of FIFO is forced to zero while empty so the stale, unreset storage never leaks out.
  assign im_data_out  = im_valid_out ? data_mem_q[rd_ptr_q] : '0;
  assign im_eol_out   = im_valid_out ? eol_mem_q[rd_ptr_q]  : 1'b0;

  // Per-lane offset add, one bit wider to catch overflow; lanes never carry into each other.
  always_comb begin
    proc_data = '0;
    lane_sum  = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = {1'b0, is_data_in[k*PIX_W +: PIX_W]} + {1'b0, cfg_offset};
      if ((SAT != 0) && lane_sum[PIX_W]) begin
        proc_data[k*PIX_W +: PIX_W] = {PIX_W{1'b1}};
      end else begin
        proc_data[k*PIX_W +: PIX_W] = lane_sum[PIX_W-1:0];
      end
    end
  end

  // End-of-line tag; ">=" lets a shortened line length resynchronise on the next beat.
  always_comb begin
    eol_tag = 1'b0;
    col_d   = col_q;
    if (cfg_line_len != '0) begin
      eol_tag = (col_q >= (cfg_line_len - LL_W'(1)));
    end
    if (push) begin
      if ((cfg_line_len == '0) || eol_tag) begin
        col_d = '0;
      end else begin
        col_d = col_q + LL_W'(1);
      end
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset; buffered beats are discarded on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      col_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      col_q    <= col_d;
    end
  end

  // FIFO storage, written with the processed beat and its eol tag on every accept.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= proc_data;
      eol_mem_q[wr_ptr_q]  <= eol_tag;
    end
  end

endmodule
